sprite_line_renderer: RTL and testbench

Parametrised per-scanline sprite engine and the successor to the fixed CTRL0-only renderer. On each start_of_line it scans the sprite attribute RAM for sprites that intersect line_y. For each hit it fetches pixel rows from VRAM over the bus-master handshake (4bpp or 8bpp, with h/v flip). It then composites pixels into the line buffer using a z-priority read-modify-write. It sits between the attribute RAM and VRAM arbiter on one side and the line buffer read by the compositor on the other.

---
 rtl/sprite_pkg.sv | 48 ++++
 rtl/sprite_pixel_unpack.sv | 38 +++
 rtl/sprite_line_renderer.sv | 227 ++++++++++++++++++++++
 tb/tb_sprite_line_renderer.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and helpers for the per-scanline sprite engine.
package sprite_pkg;

    // Attribute RAM word, MSB first.
    typedef struct packed {
        logic [1:0]  z;
        logic [13:0] addr;
        logic [2:0]  w;
        logic [2:0]  h;
        logic        mode;     // 1 = 8bpp
        logic [8:0]  y;
        logic [3:0]  pal_off;
        logic        hflip;
        logic        vflip;
        logic [9:0]  x;
    } sprite_attr_t;

    localparam int unsigned AttrW = 48;

    // Line buffer entry.
    typedef struct packed {
        logic [1:0] z;
        logic [7:0] colour;
    } lb_entry_t;

    typedef enum logic [2:0] {
        StIdle,
        StScan,
        StAttr,
        StFetch,
        StRender,
        StDrain,
        StDone
    } state_e;

    localparam int unsigned RowsPerUnit = 8;

    // Sprite height in rows: 8..64.
    function automatic logic [6:0] sprite_height(input logic [2:0] h);
        return (7'(h) + 7'd1) << 3;
    endfunction

    // 32-bit words per sprite row: 1..16.
    function automatic logic [4:0] words_per_row(input logic [2:0] w, input logic mode);
        return (5'(w) + 5'd1) << mode;
    endfunction

endpackage

// File: rtl/sprite_pixel_unpack.sv
// Extracts pixel n of a fetched VRAM word and maps it to a palette colour.
module sprite_pixel_unpack (
    input  logic [31:0] word,
    input  logic        mode,
    input  logic        hflip,
    input  logic [3:0]  pal_off,
    input  logic [2:0]  n,
    output logic [7:0]  colour,
    output logic        opaque
);

    logic [2:0] pos;
    logic [7:0] byte_v;
    logic [3:0] nib;

    // Select the byte/nibble for this pixel and apply the palette rule.
    always_comb begin
        pos    = 3'd0;
        byte_v = 8'd0;
        nib    = 4'd0;
        colour = 8'd0;
        opaque = 1'b0;
        if (mode) begin
            pos    = hflip ? (3'd3 - {1'b0, n[1:0]}) : {1'b0, n[1:0]};
            byte_v = word[{pos[1:0], 3'b000} +: 8];
            // Low byte values index into the sprite's palette bank.
            colour = (byte_v < 8'd16) ? (byte_v + {pal_off, 4'b0000}) : byte_v;
            opaque = (byte_v != 8'd0);
        end else begin
            pos    = hflip ? (3'd7 - n) : n;
            byte_v = word[{pos[2:1], 3'b000} +: 8];
            nib    = pos[0] ? byte_v[3:0] : byte_v[7:4];
            colour = {pal_off, nib};
            opaque = (nib != 4'd0);
        end
    end

endmodule

// File: rtl/sprite_line_renderer.sv
// Scanline sprite engine: scan attributes, fetch rows from VRAM, z-composite into the line buffer.
module sprite_line_renderer
    import sprite_pkg::*;
#(
    parameter int unsigned NUM_SPRITES  = 128,
    parameter int unsigned XW           = 10,
    parameter int unsigned LINE_WIDTH   = 640,
    parameter int unsigned MAX_PER_LINE = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_of_line,
    input  logic [8:0]    line_y,
    input  logic          enable,
    output logic [7:0]    sprite_idx,
    input  logic [47:0]   sprite_attr,
    output logic [15:0]   bus_addr,
    output logic          bus_strobe,
    input  logic [31:0]   bus_rddata,
    input  logic          bus_ack,
    output logic [XW-1:0] linebuf_rdidx,
    input  logic [9:0]    linebuf_rddata,
    output logic [XW-1:0] linebuf_wridx,
    output logic [9:0]    linebuf_wrdata,
    output logic          linebuf_wren,
    output logic          line_done,
    output logic          overflow
);

    localparam int unsigned CntW = $clog2(MAX_PER_LINE + 1);

    state_e          state_q, state_d;
    logic [8:0]      line_y_q;
    logic [7:0]      idx_q;
    logic [CntW-1:0] cnt_q;
    logic            overflow_q, ovf_clr_q, skip_done_q;
    logic            hflip_q, mode_q, drain_q;
    logic [3:0]      pal_q;
    logic [1:0]      z_q;
    logic [4:0]      wpr_q, k_q;
    logic [2:0]      p_q;
    logic [15:0]     base_q;
    logic [31:0]     word_q;
    logic [XW-1:0]   xpos_q;
    logic            s1_valid_q, s1_opaque_q;
    logic [XW-1:0]   s1_x_q;
    logic [7:0]      s1_colour_q;

    sprite_attr_t    attr;
    lb_entry_t       rd;
    logic [8:0]      ydiff;
    logic [6:0]      height;
    logic [5:0]      row;
    logic [4:0]      wpr, widx;
    logic [15:0]     base;
    logic            hit, last_idx, last_pix, last_word, busy;
    logic [CntW-1:0] cnt_inc;
    logic [7:0]      pix_colour;
    logic            pix_opaque;

    assign attr      = sprite_attr;
    assign rd        = linebuf_rddata;
    assign ydiff     = line_y_q - attr.y;
    assign height    = sprite_height(attr.h);
    assign hit       = (attr.z != 2'd0) && ({1'b0, ydiff} < {3'b000, height});
    assign row       = attr.vflip ? 6'(height - 7'd1 - ydiff[6:0]) : ydiff[5:0];
    assign wpr       = words_per_row(attr.w, attr.mode);
    assign base      = 16'({attr.addr, 3'b000}) + 16'(row) * 16'(wpr);
    assign last_idx  = (idx_q == 8'(NUM_SPRITES - 1));
    assign last_pix  = (p_q == (mode_q ? 3'd3 : 3'd7));
    assign last_word = (k_q == wpr_q - 5'd1);
    assign widx      = hflip_q ? (wpr_q - 5'd1 - k_q) : k_q;
    assign cnt_inc   = cnt_q + CntW'(1);
    assign busy      = (state_q != StIdle);

    sprite_pixel_unpack u_unpack (
        .word    (word_q),
        .mode    (mode_q),
        .hflip   (hflip_q),
        .pal_off (pal_q),
        .n       (p_q),
        .colour  (pix_colour),
        .opaque  (pix_opaque)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next-state logic; start_of_line overrides everything, aborting any line in flight.
    always_comb begin
        state_d = state_q;
        if (start_of_line) begin
            state_d = enable ? StScan : StIdle;
        end else begin
            case (state_q)
                StScan:   state_d = StAttr;
                StAttr:   state_d = hit ? StFetch : (last_idx ? StDone : StScan);
                StFetch:  if (bus_ack) state_d = StRender;
                StRender: if (last_pix) state_d = last_word ? StDrain : StFetch;
                StDrain: begin
                    if (drain_q) begin
                        state_d = ((cnt_inc == CntW'(MAX_PER_LINE)) || last_idx) ? StDone : StScan;
                    end
                end
                StDone:   state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    // FSM-decoded outputs.
    always_comb begin
        bus_strobe = 1'b0;
        line_done  = skip_done_q;
        case (state_q)
            StFetch: bus_strobe = 1'b1;
            StDone:  line_done  = 1'b1;
            default: ;
        endcase
    end

    // Scan, fetch and per-line bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_y_q    <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            overflow_q  <= 1'b0;
            ovf_clr_q   <= 1'b0;
            skip_done_q <= 1'b0;
            hflip_q     <= 1'b0;
            mode_q      <= 1'b0;
            drain_q     <= 1'b0;
            pal_q       <= '0;
            z_q         <= '0;
            wpr_q       <= '0;
            k_q         <= '0;
            p_q         <= '0;
            base_q      <= '0;
            word_q      <= '0;
            xpos_q      <= '0;
        end else begin
            skip_done_q <= 1'b0;
            // An abort's overflow pulse lasts exactly one cycle.
            if (ovf_clr_q) begin
                overflow_q <= 1'b0;
                ovf_clr_q  <= 1'b0;
            end
            if (start_of_line) begin
                line_y_q    <= line_y;
                idx_q       <= '0;
                cnt_q       <= '0;
                drain_q     <= 1'b0;
                overflow_q  <= busy;
                ovf_clr_q   <= busy;
                skip_done_q <= !enable;
            end else begin
                case (state_q)
                    StAttr: begin
                        if (hit) begin
                            hflip_q <= attr.hflip;
                            mode_q  <= attr.mode;
                            pal_q   <= attr.pal_off;
                            z_q     <= attr.z;
                            wpr_q   <= wpr;
                            base_q  <= base;
                            xpos_q  <= XW'(attr.x);
                            k_q     <= '0;
                            drain_q <= 1'b0;
                        end else begin
                            idx_q <= idx_q + 8'd1;
                        end
                    end
                    StFetch: begin
                        if (bus_ack) begin
                            word_q <= bus_rddata;
                            p_q    <= '0;
                        end
                    end
                    StRender: begin
                        xpos_q <= xpos_q + XW'(1);
                        p_q    <= p_q + 3'd1;
                        if (last_pix && !last_word) k_q <= k_q + 5'd1;
                    end
                    StDrain: begin
                        drain_q <= !drain_q;
                        if (drain_q) begin
                            cnt_q <= cnt_inc;
                            idx_q <= idx_q + 8'd1;
                            if (cnt_inc == CntW'(MAX_PER_LINE)) overflow_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Second RMW stage: holds the pixel whose line buffer entry is being read back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_opaque_q <= 1'b0;
            s1_x_q      <= '0;
            s1_colour_q <= '0;
        end else begin
            s1_valid_q  <= (state_q == StRender) && !start_of_line;
            s1_opaque_q <= pix_opaque;
            s1_x_q      <= xpos_q;
            s1_colour_q <= pix_colour;
        end
    end

    assign sprite_idx     = idx_q;
    assign bus_addr       = base_q + {11'd0, widx};
    assign overflow       = overflow_q;
    assign linebuf_rdidx  = xpos_q;
    assign linebuf_wridx  = s1_x_q;
    assign linebuf_wrdata = {z_q, s1_colour_q};
    // Strict z compare keeps the earlier (lower-index) sprite on ties.
    assign linebuf_wren   = s1_valid_q && s1_opaque_q && (32'(s1_x_q) < LINE_WIDTH)
                            && (rd.z < z_q);

endmodule

// File: tb/tb_sprite_line_renderer.sv
// Randomised and directed bench for sprite_line_renderer against a line-level reference model.
module tb_sprite_line_renderer;

    localparam int unsigned NSPR = 128;
    localparam int unsigned LW   = 640;
    localparam int unsigned MAXL = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_of_line = 1'b0;
    logic [8:0]  line_y = '0;
    logic        enable = 1'b0;
    logic [7:0]  sprite_idx;
    logic [47:0] sprite_attr = '0;
    logic [15:0] bus_addr;
    logic        bus_strobe;
    logic [31:0] bus_rddata = '0;
    logic        bus_ack = 1'b0;
    logic [9:0]  linebuf_rdidx;
    logic [9:0]  linebuf_rddata = '0;
    logic [9:0]  linebuf_wridx;
    logic [9:0]  linebuf_wrdata;
    logic        linebuf_wren;
    logic        line_done;
    logic        overflow;

    logic [47:0] attr_mem [NSPR];
    logic [31:0] vram_mem [65536];
    logic [9:0]  lb      [1024];
    logic [9:0]  lb_init [1024];
    logic [9:0]  exp_lb  [1024];
    logic        lb_clr = 1'b0;
    logic        ack_en = 1'b1;
    logic        late_ack_req = 1'b0;
    int          wr_cnt = 0;
    int          oob_cnt = 0;
    int          ack_cnt = 0;
    int          wait_cnt = 0;
    logic [15:0] last_ack_addr = '0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic        exp_ovf;
    int          exp_fetch;

    sprite_line_renderer #(
        .NUM_SPRITES  (NSPR),
        .XW           (10),
        .LINE_WIDTH   (LW),
        .MAX_PER_LINE (MAXL)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start_of_line  (start_of_line),
        .line_y         (line_y),
        .enable         (enable),
        .sprite_idx     (sprite_idx),
        .sprite_attr    (sprite_attr),
        .bus_addr       (bus_addr),
        .bus_strobe     (bus_strobe),
        .bus_rddata     (bus_rddata),
        .bus_ack        (bus_ack),
        .linebuf_rdidx  (linebuf_rdidx),
        .linebuf_rddata (linebuf_rddata),
        .linebuf_wridx  (linebuf_wridx),
        .linebuf_wrdata (linebuf_wrdata),
        .linebuf_wren   (linebuf_wren),
        .line_done      (line_done),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    // Attribute RAM, one-cycle read latency.
    always @(posedge clk) sprite_attr <= attr_mem[sprite_idx];

    // VRAM slave with random ack latency; late_ack_req injects a stray ack.
    always @(posedge clk) begin
        bus_ack <= 1'b0;
        if (late_ack_req) begin
            bus_ack    <= 1'b1;
            bus_rddata <= 32'hFFFF_FFFF;
        end else if (bus_strobe && !bus_ack && ack_en) begin
            if (wait_cnt == 0) begin
                bus_ack       <= 1'b1;
                bus_rddata    <= vram_mem[bus_addr];
                ack_cnt       <= ack_cnt + 1;
                last_ack_addr <= bus_addr;
                wait_cnt      <= $urandom_range(0, 3);
            end else begin
                wait_cnt <= wait_cnt - 1;
            end
        end
    end

    // Line buffer, one-cycle read latency.
    always @(posedge clk) begin
        linebuf_rddata <= lb[linebuf_rdidx];
        if (lb_clr) begin
            for (int i = 0; i < 1024; i++) lb[i] <= lb_init[i];
        end else if (linebuf_wren) begin
            lb[linebuf_wridx] <= linebuf_wrdata;
            wr_cnt <= wr_cnt + 1;
            if (int'(linebuf_wridx) >= int'(LW)) oob_cnt <= oob_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [47:0] mk_attr(int x, bit vf, bit hf, int pal, int y, bit md,
                                            int h, int w, int addr, int z);
        logic [47:0] a;
        a = '0;
        a[9:0]   = 10'(x);
        a[10]    = vf;
        a[11]    = hf;
        a[15:12] = 4'(pal);
        a[24:16] = 9'(y);
        a[25]    = md;
        a[28:26] = 3'(h);
        a[31:29] = 3'(w);
        a[45:32] = 14'(addr);
        a[47:46] = 2'(z);
        return a;
    endfunction

    // Reference: sprites in index order, each painting its row at full-row granularity.
    task automatic model_line(input logic [8:0] ly);
        logic [47:0] a;
        logic [31:0] word;
        int rendered, x0, vf, hf, pal, sy, md, h, w, base, z;
        int hgt, wid, yd, r, ppw, wpr, sc, pix, col, x, ni, b;
        exp_ovf   = 1'b0;
        exp_fetch = 0;
        rendered  = 0;
        for (int i = 0; i < 1024; i++) exp_lb[i] = lb_init[i];
        for (int s = 0; s < int'(NSPR) && !exp_ovf; s++) begin
            a    = attr_mem[s];
            x0   = int'(a[9:0]);
            vf   = int'(a[10]);
            hf   = int'(a[11]);
            pal  = int'(a[15:12]);
            sy   = int'(a[24:16]);
            md   = int'(a[25]);
            h    = int'(a[28:26]);
            w    = int'(a[31:29]);
            base = int'(a[45:32]);
            z    = int'(a[47:46]);
            hgt  = 8 * (h + 1);
            wid  = 8 * (w + 1);
            yd   = (int'(ly) - sy + 512) % 512;
            if (z == 0 || yd >= hgt) continue;
            r    = (vf != 0) ? hgt - 1 - yd : yd;
            ppw  = (md != 0) ? 4 : 8;
            wpr  = wid / ppw;
            exp_fetch += wpr;
            for (int c = 0; c < wid; c++) begin
                sc   = (hf != 0) ? wid - 1 - c : c;
                word = vram_mem[(base * 8 + r * wpr + sc / ppw) % 65536];
                if (md != 0) begin
                    pix = int'((word >> (8 * (sc % 4))) & 32'hFF);
                    col = (pix < 16) ? (pix + 16 * pal) % 256 : pix;
                end else begin
                    ni  = sc % 8;
                    b   = int'((word >> (8 * (ni / 2))) & 32'hFF);
                    pix = (ni % 2 == 0) ? b / 16 : b % 16;
                    col = pal * 16 + pix;
                end
                x = (x0 + c) % 1024;
                if (pix != 0 && x < int'(LW) && int'(exp_lb[x][9:8]) < z)
                    exp_lb[x] = {2'(z), 8'(col)};
            end
            rendered++;
            if (rendered == int'(MAXL)) exp_ovf = 1'b1;
        end
    endtask

    task automatic clear_attrs();
        for (int i = 0; i < int'(NSPR); i++) attr_mem[i] = '0;
    endtask

    task automatic load_lb();
        @(negedge clk);
        lb_clr = 1'b1;
        @(negedge clk);
        lb_clr = 1'b0;
    endtask

    task automatic pulse_line(input logic [8:0] y, input logic en);
        @(negedge clk);
        line_y        = y;
        enable        = en;
        start_of_line = 1'b1;
        @(negedge clk);
        start_of_line = 1'b0;
    endtask

    task automatic wait_done(output logic seen, output logic ovf);
        seen = 1'b0;
        ovf  = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            if (line_done) begin
                seen = 1'b1;
                ovf  = overflow;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_line(input string tag, input logic [8:0] y);
        int   ack0, nerr;
        logic seen, ovf;
        model_line(y);
        load_lb();
        ack0 = ack_cnt;
        pulse_line(y, 1'b1);
        wait_done(seen, ovf);
        check_eq({tag, "_done"}, 64'(seen), 64'd1);
        check_eq({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
        check_eq({tag, "_fetches"}, 64'(ack_cnt - ack0), 64'(exp_fetch));
        nerr = 0;
        for (int i = 0; i < 1024; i++) if (lb[i] !== exp_lb[i]) nerr++;
        check_eq({tag, "_lb_mismatches"}, 64'(nerr), 64'd0);
        check_eq({tag, "_oob_writes"}, 64'(oob_cnt), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic       seen, ovf;
        int         wr0, ack0, nz;
        logic [8:0] ly;

        for (int i = 0; i < 65536; i++) vram_mem[i] = $urandom;
        for (int i = 0; i < 1024; i++) lb_init[i] = '0;
        clear_attrs();

        repeat (3) @(negedge clk);
        check_eq("reset_outputs",
                 {sprite_idx, bus_addr, bus_strobe, linebuf_wren, line_done, overflow,
                  linebuf_rdidx, linebuf_wridx, linebuf_wrdata}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Disabled line: immediate done, no work.
        wr0 = wr_cnt;
        pulse_line(9'd12, 1'b0);
        check_eq("disabled_done", 64'(line_done), 64'd1);
        @(negedge clk);
        check_eq("disabled_no_writes", 64'(wr_cnt - wr0), 64'd0);

        // Basic 4bpp sprite.
        attr_mem[0] = mk_attr(100, 0, 0, 0, 10, 0, 0, 0, 'h20, 3);
        vram_mem[16'h0102] = 32'h0000_0021;
        run_line("t1", 9'd12);
        check_eq("t1_bus_addr", 64'(last_ack_addr), 64'h0102);
        check_eq("t1_x100", 64'(lb[100]), 64'h302);
        check_eq("t1_x101", 64'(lb[101]), 64'h301);
        nz = 0;
        for (int i = 102; i < 108; i++) if (lb[i] != 10'd0) nz++;
        check_eq("t1_transparent", 64'(nz), 64'd0);

        // Horizontal flip.
        attr_mem[0] = mk_attr(100, 0, 1, 0, 10, 0, 0, 0, 'h20, 3);
        vram_mem[16'h0102] = 32'h2100_0000;
        run_line("t2", 9'd12);
        check_eq("t2_x100", 64'(lb[100]), 64'h301);
        check_eq("t2_x101", 64'(lb[101]), 64'h302);

        // Equal z: lower index wins; higher z overwrites.
        attr_mem[0] = mk_attr(100, 0, 0, 0, 10, 0, 0, 0, 'h20, 2);
        attr_mem[1] = mk_attr(100, 0, 0, 0, 10, 0, 0, 0, 'h40, 2);
        vram_mem[16'h0102] = 32'h1111_1111;
        vram_mem[16'h0202] = 32'h2222_2222;
        run_line("t3a", 9'd12);
        check_eq("t3a_tie_keeps_idx0", 64'(lb[100]), 64'h201);
        attr_mem[1] = mk_attr(100, 0, 0, 0, 10, 0, 0, 0, 'h40, 3);
        run_line("t3b", 9'd12);
        check_eq("t3b_higher_z", 64'(lb[100]), 64'h302);

        // 8bpp wrap around x=1023, right edge clipped by LINE_WIDTH, palette on low bytes.
        clear_attrs();
        attr_mem[0] = mk_attr(1020, 0, 0, 3, 12, 1, 0, 0, 'h30, 1);
        vram_mem[16'h0180] = 32'h4433_2211;
        vram_mem[16'h0181] = 32'h8877_6605;
        run_line("t4", 9'd12);
        check_eq("t4_x0_pal", 64'(lb[0]), 64'h135);
        check_eq("t4_x3", 64'(lb[3]), 64'h188);
        check_eq("t4_x1023_clipped", 64'(lb[1023]), 64'h000);

        // Overflow: 70 hitting sprites, only 64 rendered.
        clear_attrs();
        for (int i = 0; i < 70; i++) attr_mem[i] = mk_attr(i * 8, 0, 0, i % 16, 12, 0, 0, 0, i, 1);
        run_line("t5", 9'd12);
        check_eq("t5_exact64", 64'(exp_fetch), 64'd64);

        // Abort while waiting for ack.
        clear_attrs();
        attr_mem[5] = mk_attr(200, 0, 0, 0, 10, 0, 0, 0, 'h20, 1);
        load_lb();
        ack_en = 1'b0;
        wr0    = wr_cnt;
        ack0   = ack_cnt;
        pulse_line(9'd12, 1'b1);
        seen = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (bus_strobe) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq("abort_strobe_seen", 64'(seen), 64'd1);
        repeat (3) @(negedge clk);
        line_y        = 9'd300;
        enable        = 1'b1;
        start_of_line = 1'b1;
        @(negedge clk);
        start_of_line = 1'b0;
        check_eq("abort_strobe_dropped", 64'(bus_strobe), 64'd0);
        check_eq("abort_ovf_pulse", 64'(overflow), 64'd1);
        check_eq("abort_idx_restart", 64'(sprite_idx), 64'd0);
        @(negedge clk);
        check_eq("abort_ovf_cleared", 64'(overflow), 64'd0);
        late_ack_req = 1'b1;
        @(negedge clk);
        late_ack_req = 1'b0;
        ack_en       = 1'b1;
        wait_done(seen, ovf);
        check_eq("abort_new_line_done", 64'(seen), 64'd1);
        check_eq("abort_new_line_ovf", 64'(ovf), 64'd0);
        check_eq("abort_no_writes", 64'(wr_cnt - wr0), 64'd0);
        check_eq("abort_no_fetches", 64'(ack_cnt - ack0), 64'd0);

        // Randomised lines against the reference model.
        for (int t = 0; t < 6; t++) begin
            ly = 9'($urandom_range(0, 479));
            for (int i = 0; i < int'(NSPR); i++) begin
                attr_mem[i] = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
                if ($urandom_range(0, 5) == 0)
                    attr_mem[i][24:16] = 9'(int'(ly) - int'($urandom_range(0, 70)));
            end
            for (int i = 0; i < 1024; i++)
                lb_init[i] = ($urandom_range(0, 1) == 0) ? 10'd0 : 10'($urandom);
            run_line($sformatf("rand%0d", t), ly);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
